// File: rtl/truth_table_sweeper.sv
// Exhaustive on-chip truth-table tester: walks every input vector of an N_IN-input
// combinational DUT, captures its response table and compares it with a latched expectation.
module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [(1<<N_IN)-1:0]  exp_tt,
    output logic [N_IN-1:0]       dut_in,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_IN:0]         err_count,
    output logic [N_IN-1:0]       first_err,
    output logic                  first_err_valid,
    output logic [(1<<N_IN)-1:0]  resp_tt
);
    localparam int NV = 1 << N_IN;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [NV-1:0]   exp_latched;
    logic [3:0]      cnt;
    logic            settle_end;
    logic            last;
    logic            mismatch;
    logic [N_IN:0]   err_nxt;

    // dut_in doubles as the sweep index; it always equals the vector under test
    assign settle_end = (cnt == 4'(SETTLE - 1));
    assign last       = &dut_in;
    assign mismatch   = (dut_out != exp_latched[dut_in]);
    assign err_nxt    = err_count + {{N_IN{1'b0}}, mismatch};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: if (settle_end) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = last ? S_DONE : S_SETTLE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_latched     <= '0;
            cnt             <= '0;
            dut_in          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
            resp_tt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        exp_latched     <= exp_tt;
                        dut_in          <= '0;
                        busy            <= 1'b1;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        resp_tt         <= '0;
                        pass            <= 1'b0;
                        cnt             <= '0;
                    end
                end
                S_SETTLE: begin
                    if (!settle_end) cnt <= cnt + 4'd1;
                end
                S_SAMPLE: begin
                    resp_tt[dut_in] <= dut_out;
                    err_count       <= err_nxt;
                    cnt             <= '0;
                    if (mismatch && !first_err_valid) begin
                        first_err       <= dut_in;
                        first_err_valid <= 1'b1;
                    end
                    // pass must include the final sample, hence err_nxt rather than err_count
                    if (last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_nxt == '0);
                    end else begin
                        dut_in <= dut_in + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: stimulus pushes the expected sweep outcome, a negedge monitor checks
// per-cycle dut_in/busy progress, the done result and the held idle values.
module tb_truth_table_sweeper;
    localparam int N  = 3;
    localparam int S  = 2;
    localparam int NV = 1 << N;
    localparam int E  = NV * (S + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NV-1:0] exp_tt = '0;
    logic [NV-1:0] f_tt = '0;
    logic [N-1:0]  dut_in;
    logic          dut_out;
    logic          busy, done, pass, first_err_valid;
    logic [N:0]    err_count;
    logic [N-1:0]  first_err;
    logic [NV-1:0] resp_tt;

    truth_table_sweeper #(.N_IN(N), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .start(start), .exp_tt(exp_tt), .dut_in(dut_in),
        .dut_out(dut_out), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err(first_err), .first_err_valid(first_err_valid), .resp_tt(resp_tt)
    );

    always #5 clk = ~clk;
    assign dut_out = f_tt[dut_in];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            c0;
        logic [NV-1:0] e;
        logic [NV-1:0] f;
    } sweep_t;

    sweep_t sb[$];
    int checks = 0, errors = 0;

    // values the outputs must hold while idle
    logic [NV-1:0] h_resp = '0;
    int            h_err = 0, h_fe = 0, h_fev = 0, h_pass = 0, h_din = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int popcnt(input logic [NV-1:0] v);
        int n = 0;
        for (int i = 0; i < NV; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int lowest(input logic [NV-1:0] v);
        for (int i = 0; i < NV; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    sweep_t x;
                    logic [NV-1:0] d;
                    x = sb.pop_front();
                    d = x.f ^ x.e;
                    chk("done_cycle", cyc, x.c0 + E);
                    chk("resp_tt", resp_tt, x.f);
                    chk("err_count", err_count, popcnt(d));
                    chk("first_err_valid", first_err_valid, d != '0);
                    if (d != '0) chk("first_err", first_err, lowest(d));
                    chk("pass", pass, d == '0);
                    chk("busy_at_done", busy, 0);
                    chk("dut_in_at_done", dut_in, NV - 1);
                    h_resp = x.f; h_err = popcnt(d); h_fev = (d != '0);
                    h_fe = (d != '0) ? lowest(d) : 0; h_pass = (d == '0); h_din = NV - 1;
                end
            end else if (sb.size() > 0) begin
                if (cyc >= sb[0].c0) begin
                    if (cyc >= sb[0].c0 + E) begin
                        chk("done_missing", 0, 1);
                        void'(sb.pop_front());
                    end else begin
                        chk("busy", busy, 1);
                        chk("dut_in_walk", dut_in, (cyc - sb[0].c0) / (S + 1));
                    end
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_resp_tt", resp_tt, h_resp);
                chk("idle_err_count", err_count, h_err);
                chk("idle_first_err_valid", first_err_valid, h_fev);
                if (h_fev != 0) chk("idle_first_err", first_err, h_fe);
                chk("idle_pass", pass, h_pass);
                chk("idle_dut_in", dut_in, h_din);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [NV-1:0] f, input logic [NV-1:0] e, input bit poke);
        step();
        f_tt = f; exp_tt = e; start = 1'b1;
        sb.push_back('{c0: cyc + 1, e: e, f: f});
        step();
        start = 1'b0;
        for (int i = 0; i < E + 4; i++) begin
            exp_tt = NV'($urandom);
            start  = poke && (i == 5);
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        logic [NV-1:0] f;
        int c0;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        f = NV'($urandom);
        run(f, f, 1'b0);
        run('0, '1, 1'b0);
        run(f, f ^ NV'(1 << (NV - 1)), 1'b0);
        run(f, f ^ NV'(1), 1'b1);
        for (int k = 0; k < 4; k++) run(NV'($urandom), NV'($urandom), k == 1);

        // abort mid-sweep: results wiped, no done
        step();
        f_tt = NV'($urandom); exp_tt = NV'($urandom); start = 1'b1;
        sb.push_back('{c0: cyc + 1, e: exp_tt, f: f_tt});
        step();
        start = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        void'(sb.pop_back());
        h_resp = '0; h_err = 0; h_fe = 0; h_fev = 0; h_pass = 0; h_din = 0;
        step();
        rst = 1'b0;
        repeat (3) step();
        run(f, f ^ NV'(8'h5A), 1'b0);

        // start held high: back-to-back sweeps E+2 edges apart
        step();
        f_tt = NV'($urandom); exp_tt = NV'($urandom); start = 1'b1;
        c0 = cyc + 1;
        sb.push_back('{c0: c0, e: exp_tt, f: f_tt});
        sb.push_back('{c0: c0 + E + 2, e: exp_tt, f: f_tt});
        while (cyc < c0 + E + 2) step();
        start = 1'b0;
        repeat (E + 4) step();

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
